// File: rtl/wtf_alu_accum.sv
// Switch/key ALU stage: synchronises switches, debounces four keys, and holds a
// stored operand that the selected ALU op combines with the switch value.
`timescale 1ns/1ps
module wtf_alu_accum #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    input  logic [3:0]       key,
    output logic [WIDTH-1:0] stored_value,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       op,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic [3:0]       key_pulse
);

    localparam int unsigned NKEYS = 4;
    localparam int unsigned MSB   = WIDTH - 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_sync;
    logic [NKEYS-1:0] key_meta;
    logic [NKEYS-1:0] key_sync;
    logic [NKEYS-1:0] key_state;
    logic [CNT_W-1:0] deb_cnt [NKEYS];

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [WIDTH-1:0] alu_res_c;
    logic             alu_carry_c;
    logic             alu_ovf_c;
    logic [WIDTH-1:0] stored_next_c;
    logic [2:0]       op_next_c;

    // Two-flop synchronisers for the asynchronous switch and key inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            key_meta <= key;
            key_sync <= key_meta;
        end
    end

    // Per-key debounce; a level must differ for DEBOUNCE_CYCLES samples to flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NKEYS); i++) begin
                deb_cnt[i] <= '0;
            end
            key_state <= '0;
            key_pulse <= '0;
        end else begin
            key_pulse <= '0;
            for (int i = 0; i < int'(NKEYS); i++) begin
                if (key_sync[i] == key_state[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    deb_cnt[i]   <= '0;
                    key_state[i] <= key_sync[i];
                    key_pulse[i] <= key_sync[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // ALU evaluated one bit wider so the top bit gives carry / borrow.
    always_comb begin
        sum_c       = {1'b0, sw_sync} + {1'b0, stored_value};
        diff_c      = {1'b0, sw_sync} - {1'b0, stored_value};
        alu_res_c   = '0;
        alu_carry_c = 1'b0;
        alu_ovf_c   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res_c   = sum_c[WIDTH-1:0];
                alu_carry_c = sum_c[WIDTH];
                alu_ovf_c   = (sw_sync[MSB] == stored_value[MSB]) && (sum_c[MSB] != sw_sync[MSB]);
            end
            OP_SUB: begin
                alu_res_c   = diff_c[WIDTH-1:0];
                alu_carry_c = diff_c[WIDTH];
                alu_ovf_c   = (sw_sync[MSB] != stored_value[MSB]) && (diff_c[MSB] != sw_sync[MSB]);
            end
            OP_AND:  alu_res_c = sw_sync & stored_value;
            OP_OR:   alu_res_c = sw_sync | stored_value;
            OP_XOR:  alu_res_c = sw_sync ^ stored_value;
            default: alu_res_c = '0;
        endcase
    end

    // Key actions: clear dominates, then accumulate, then store.
    always_comb begin
        stored_next_c = stored_value;
        op_next_c     = op;
        if (key_pulse[3]) begin
            stored_next_c = '0;
        end else if (key_pulse[2]) begin
            stored_next_c = result;
        end else if (key_pulse[1]) begin
            stored_next_c = sw_sync;
        end
        if (key_pulse[3]) begin
            op_next_c = OP_ADD;
        end else if (key_pulse[0]) begin
            op_next_c = (op == OP_XOR) ? OP_ADD : op + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored_value <= '0;
            op           <= OP_ADD;
            result       <= '0;
            carry        <= 1'b0;
            ovf          <= 1'b0;
            zero         <= 1'b1;
        end else begin
            stored_value <= stored_next_c;
            op           <= op_next_c;
            result       <= alu_res_c;
            carry        <= alu_carry_c;
            ovf          <= alu_ovf_c;
            zero         <= (alu_res_c == '0);
        end
    end

endmodule

// File: doc/wtf_alu_accum.md
Name: wtf_alu_accum

Overview:
Parametrised successor to the switch/key add-subtract stage of the WTFpga top level. It takes WIDTH-bit switch input and four push keys, and debounces and edge-detects the keys in-block. It holds a stored operand, cycles through five ALU ops, and can accumulate the result back into storage. Outputs are registered values and flags; the existing nibble-to-seven-seg decoders and seven_seg_mux consume them for display.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, multiple of 4 for nibble display)
DEBOUNCE_CYCLES, 50000, clk cycles a synchronised key level must hold before it is accepted (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
sw  in  WIDTH  switch operand A, asynchronous to clk
key  in  4  raw push keys, active-high pressed, asynchronous, bouncy
stored_value  out  WIDTH  stored operand B
result  out  WIDTH  registered ALU result
op  out  3  current op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
carry  out  1  ADD carry-out / SUB borrow; 0 for logic ops
ovf  out  1  signed two's-complement overflow (ADD/SUB only)
zero  out  1  result == 0
key_pulse  out  4  one-cycle press pulses after debounce (debug/LED use)

Behaviour:
- Reset (rst_n low, async): stored_value=0, result=0, op=0 (ADD), carry=0, ovf=0, zero=1, key_pulse=0. All synchronisers, debounce counters and debounced key states are cleared to 0 (not pressed). Deassertion is synchronous in effect: first active edge after rst_n rises is a normal cycle.
- Input sync: sw and key pass through a 2-flop synchroniser each.
- Debounce, per key: counter resets to 0 whenever sync level == debounced state. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 and the sync level still differs, the debounced state flips and the counter clears. A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- key_pulse[i]: high for exactly one cycle on the cycle the debounced state of key i goes 0->1. Release produces no pulse. A held key produces one pulse only.
- Key actions, applied on the cycle after key_pulse:
  - key[0]: op advances ADD->SUB->AND->OR->XOR->ADD. Wraps at 4; values 5-7 are never reached.
  - key[1] store: stored_value <= sw_sync.
  - key[2] accumulate: stored_value <= result (current registered value).
  - key[3] clear: stored_value <= 0, op <= ADD.
- Simultaneous pulses: clear beats accumulate beats store for stored_value. Clear beats op-cycle for op. Op-cycle and store/accumulate otherwise combine in the same cycle.
- ALU, registered every cycle with A=sw_sync, B=stored_value, computed at WIDTH+1 bits:
  - ADD: result=A+B mod 2^WIDTH; carry=bit WIDTH; ovf = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
  - SUB: result=A-B mod 2^WIDTH; carry=1 iff A<B unsigned; ovf = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
  - AND/OR/XOR: bitwise; carry=0; ovf=0.
  - zero registered alongside result.
- Latency: sw edge -> result updated 3 clk edges later (2 sync + 1 register). Key press stable -> key_pulse after 2 + DEBOUNCE_CYCLES edges. Action visible on stored_value/op one edge after the pulse; new result one edge after that.
- Reset mid-debounce or mid-press: all state is discarded. A key still held after reset must re-debounce and then produces a fresh pulse.

Test Plan:
(Bench uses WIDTH=8, DEBOUNCE_CYCLES=4.)
- Reset: assert rst_n=0 mid-cycle -> outputs zero immediately, zero=1, op=0. Release, sw=8'h3C -> result=8'h3C on the 3rd edge, zero=0.
- Store + ADD overflow: sw=8'h70, press key[1] (hold 10 cycles) -> exactly one key_pulse[1], stored=8'h70. Then sw=8'h20 -> result=8'h90, carry=0, ovf=1. Then sw=8'hA0 -> result=8'h10, carry=1, ovf=0.
- Bounce rejection: toggle key[0] high for 2 cycles, low 1, high 3, low -> no key_pulse, op unchanged. Then hold 8 cycles -> one pulse, op=1 (SUB).
- SUB borrow and zero: op=SUB, stored=8'h05, sw=8'h03 -> result=8'hFE, carry=1. sw=8'h05 -> result=0, zero=1, carry=0.
- Op wrap + accumulate: press key[0] five times from ADD -> op sequence 1,2,3,4,0. op=ADD, stored=1, sw=1, press key[2] three times -> stored goes 2, 3, 4.
- Simultaneous: key[1], key[2] and key[3] pulse on the same cycle with key[0] also pressed -> stored=0, op=0. Separately, rst_n pulsed while key[1] held -> one new pulse after re-debounce, not before.
